// File: rtl/uart_avalon_if_if.sv
// Avalon-MM slave bus bundle for the UART register front-end.
// The master modport drives address/strobes/writedata; the slave returns readdata.
interface uart_avalon_if_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/uart_avalon_if.sv
// Avalon-MM register front-end for the UART core: TX/RX byte FIFOs, status, divisor, interrupt.
// Optional macro UART_IRQ_EN adds the IER register (address 3) and the registered irq output.
module uart_avalon_if #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic                   clk,
    input  logic                   reset_n,
    uart_avalon_if_if.slave        avs,
    output logic                   irq,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    input  logic                   rx_ready,
    input  logic [7:0]             rx_data,
    output logic [15:0]            clk_div
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_IER    = 2'd3;

    // Bus decode; a read paired with a write is dropped entirely.
    logic        rd_en;
    logic        wr_data, wr_status, wr_ctrl, wr_ier;
    logic        rd_data;
    logic        tx_flush, rx_flush;
    logic [31:0] wdata;

    assign wdata     = avs.avs_writedata;
    assign rd_en     = avs.avs_read && !avs.avs_write;
    assign wr_data   = avs.avs_write && (avs.avs_address == ADDR_DATA);
    assign wr_status = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    assign wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign wr_ier    = avs.avs_write && (avs.avs_address == ADDR_IER);
    assign rd_data   = rd_en && (avs.avs_address == ADDR_DATA);
    assign tx_flush  = wr_ctrl && wdata[16];
    assign rx_flush  = wr_ctrl && wdata[17];

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:18];

    // TX FIFO
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_empty, tx_full, tx_pop, tx_push, tx_ovf_set;

    assign tx_empty   = (tx_cnt_q == '0);
    assign tx_full    = (tx_cnt_q == FULL_CNT);
    assign tx_valid   = !tx_empty;
    assign tx_data    = tx_empty ? 8'h00 : tx_mem[tx_rd_q];
    assign tx_pop     = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign tx_push    = wr_data && (!tx_full || tx_pop) && !tx_flush;
    assign tx_ovf_set = wr_data && tx_full && !tx_pop && !tx_flush;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_flush) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + PTR_W'(1);
            if (tx_pop)  tx_rd_d = tx_rd_q + PTR_W'(1);
            tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= wdata[7:0];
    end

    // RX FIFO
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             rx_empty, rx_full, rx_pop, rx_push, rx_ovr_set;
    logic [7:0]       rx_head;

    assign rx_empty   = (rx_cnt_q == '0);
    assign rx_full    = (rx_cnt_q == FULL_CNT);
    assign rx_head    = rx_mem[rx_rd_q];
    assign rx_pop     = rd_data && !rx_empty && !rx_flush;
    assign rx_push    = rx_ready && (!rx_full || rx_pop) && !rx_flush;
    assign rx_ovr_set = rx_ready && rx_full && !rx_pop && !rx_flush;

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_flush) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + PTR_W'(1);
            if (rx_pop)  rx_rd_d = rx_rd_q + PTR_W'(1);
            rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_data;
    end

    // Sticky error flags; a new event wins over a W1C in the same cycle.
    logic tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    assign tx_ovf_d = (tx_ovf_q && !(wr_status && wdata[4])) || tx_ovf_set;
    assign rx_ovr_d = (rx_ovr_q && !(wr_status && wdata[5])) || rx_ovr_set;

    logic [15:0] div_q, div_d;
    assign div_d   = wr_ctrl ? wdata[15:0] : div_q;
    assign clk_div = div_q;

    logic [31:0] ier_rd;
`ifdef UART_IRQ_EN
    logic [2:0] ier_q, ier_d;
    logic       irq_q;
    assign ier_d  = wr_ier ? wdata[2:0] : ier_q;
    assign ier_rd = {29'd0, ier_q};
    assign irq    = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ier_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ier_q <= ier_d;
            irq_q <= |(ier_q & {tx_ovf_q | rx_ovr_q, tx_empty, !rx_empty});
        end
    end
`else
    logic unused_ier;
    assign unused_ier = wr_ier;
    assign ier_rd     = 32'd0;
    assign irq        = 1'b0;
`endif

    logic [31:0] status;
    always_comb begin
        status              = 32'd0;
        status[0]           = tx_empty;
        status[1]           = tx_full;
        status[2]           = !rx_empty;
        status[3]           = rx_full;
        status[4]           = tx_ovf_q;
        status[5]           = rx_ovr_q;
        status[8 +: CNT_W]  = tx_cnt_q;
        status[16 +: CNT_W] = rx_cnt_q;
    end

    // Read data is captured on the sampling edge and held until the next read.
    logic [31:0] rdata_q, rdata_d;
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (avs.avs_address)
                ADDR_DATA:   rdata_d = rx_pop ? {23'd0, 1'b1, rx_head} : 32'd0;
                ADDR_STATUS: rdata_d = status;
                ADDR_CTRL:   rdata_d = {16'd0, div_q};
                ADDR_IER:    rdata_d = ier_rd;
                default:     rdata_d = 32'd0;
            endcase
        end
    end
    assign avs.avs_readdata = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
            div_q    <= DIV_RESET;
            rdata_q  <= 32'd0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovr_q <= rx_ovr_d;
            div_q    <= div_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_avalon_if.sv
// Directed bench for uart_avalon_if: register vector table plus hand-written FIFO/irq sequences.
module tb_uart_avalon_if;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       irq;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [15:0] clk_div;

    int checks = 0;
    int errors = 0;

    uart_avalon_if_if bus ();

    uart_avalon_if dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus),
        .irq      (irq),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .clk_div  (clk_div)
    );

    always #5 clk = ~clk;

`ifdef UART_IRQ_EN
    localparam logic [31:0] IER_RB = 32'h7;
`else
    localparam logic [31:0] IER_RB = 32'h0;
`endif

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        data            = bus.avs_readdata;
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        bus.avs_address   = 2'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'd0;

        vecs[0]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0001};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,        32'h0000_01B2};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
        vecs[4]  = '{1'b1, 2'd2, 32'h0000_1234, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,        32'h0000_1234};
        vecs[6]  = '{1'b1, 2'd2, 32'h0003_01B2, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,        32'h0000_01B2};
        vecs[8]  = '{1'b1, 2'd0, 32'h0000_0041, 32'h0};
        vecs[9]  = '{1'b1, 2'd0, 32'h0000_0142, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 32'h0,        32'h0000_0200};
        vecs[11] = '{1'b1, 2'd3, 32'h0000_0007, 32'h0};
        vecs[12] = '{1'b0, 2'd3, 32'h0,        IER_RB};
        vecs[13] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0};
        vecs[14] = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};

        #22;
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_clk_div", {16'd0, clk_div}, 32'h1B2);
        check("reset_readdata", bus.avs_readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end
        check("clk_div_out", {16'd0, clk_div}, 32'h1B2);
        check("tx_valid_2", {31'd0, tx_valid}, 32'd1);
        check("tx_head_41", {24'd0, tx_data}, 32'h41);

        // TX drain by the core
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_head_42", {24'd0, tx_data}, 32'h42);
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_drained", {31'd0, tx_valid}, 32'd0);

        // TX overflow, pop-rescued push, flush keeps sticky flag
        for (int i = 0; i < 17; i++) bus_write(2'd0, i);
        read_check("tx_ovf_status", 2'd1, 32'h0000_1012);
        bus_write(2'd1, 32'h10);
        read_check("tx_ovf_w1c", 2'd1, 32'h0000_1002);
        tx_ready = 1'b1;
        bus_write(2'd0, 32'hA5);
        tx_ready = 1'b0;
        read_check("tx_full_pushpop", 2'd1, 32'h0000_1002);
        check("tx_head_after_pop", {24'd0, tx_data}, 32'h01);
        bus_write(2'd0, 32'hA6);
        read_check("tx_ovf_again", 2'd1, 32'h0000_1012);
        bus_write(2'd2, 32'h0001_01B2);
        read_check("tx_flush_sticky", 2'd1, 32'h0000_0011);
        bus_write(2'd1, 32'h10);
        read_check("tx_ovf_cleared", 2'd1, 32'h0000_0001);

        // Flush with 5 bytes queued, DATA write right behind it
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h60 + i);
        bus_write(2'd2, 32'h0001_01B2);
        check("flush_tx_valid", {31'd0, tx_valid}, 32'd0);
        bus_write(2'd0, 32'h77);
        read_check("flush_then_push", 2'd1, 32'h0000_0100);
        check("flush_head_77", {24'd0, tx_data}, 32'h77);
        read_check("flush_div_kept", 2'd2, 32'h0000_01B2);
        bus_write(2'd2, 32'h0001_01B2);

        // RX basic
        rx_strobe(8'h55);
        rx_strobe(8'hAA);
        read_check("rx_55", 2'd0, 32'h155);
        read_check("rx_AA", 2'd0, 32'h1AA);
        read_check("rx_empty", 2'd0, 32'h000);

        // RX full, overrun, simultaneous pop+push
        for (int i = 0; i < 16; i++) rx_strobe(8'h10 + 8'(i));
        read_check("rx_full_status", 2'd1, 32'h0010_000D);
        rx_strobe(8'h99);
        read_check("rx_ovr_status", 2'd1, 32'h0010_002D);
        bus_write(2'd1, 32'h20);
        read_check("rx_ovr_w1c", 2'd1, 32'h0010_000D);
        rx_data  = 8'hEE;
        rx_ready = 1'b1;
        bus_read(2'd0, d);
        rx_ready = 1'b0;
        check("rx_popush_data", d, 32'h110);
        read_check("rx_popush_status", 2'd1, 32'h0010_000D);
        for (int i = 1; i < 16; i++) read_check($sformatf("rx_drain%0d", i), 2'd0, 32'h110 + i);
        read_check("rx_drain_last", 2'd0, 32'h1EE);
        read_check("rx_drained_status", 2'd1, 32'h0000_0001);

        // Interrupt timing
`ifdef UART_IRQ_EN
        bus_write(2'd3, 32'h1);
        rx_strobe(8'h3C);
        check("irq_lat1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_lat2", {31'd0, irq}, 32'd1);
        bus_read(2'd0, d);
        check("irq_pop_data", d, 32'h13C);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_clear", {31'd0, irq}, 32'd0);
        bus_write(2'd3, 32'h2);
        @(negedge clk);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h0);
        @(negedge clk);
        check("irq_off", {31'd0, irq}, 32'd0);
`else
        bus_write(2'd3, 32'h7);
        rx_strobe(8'h3C);
        @(negedge clk);
        check("irq_tied", {31'd0, irq}, 32'd0);
        read_check("ier_absent", 2'd3, 32'h0);
        read_check("irq_pop_data", 2'd0, 32'h13C);
`endif

        // Read+write together: write lands, read ignored, readdata held
        rx_strobe(8'h33);
        read_check("pre_rw_ctrl", 2'd2, 32'h1B2);
        bus.avs_read = 1'b1;
        bus_write(2'd0, 32'h44);
        bus.avs_read = 1'b0;
        @(negedge clk);
        check("rw_readdata_held", bus.avs_readdata, 32'h1B2);
        check("rw_tx_head", {24'd0, tx_data}, 32'h44);
        read_check("rw_rx_kept", 2'd0, 32'h133);

        // Asynchronous reset mid-transfer
        bus_write(2'd2, 32'h55);
        rx_strobe(8'h12);
        #1 reset_n = 1'b0;
        #1;
        check("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("arst_clk_div", {16'd0, clk_div}, 32'h1B2);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_check("arst_status", 2'd1, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
